gb_fb_writer: RTL and testbench

- Downstream consumer of the PPU pixel stream.
- Takes raw 2-bit pixel codes, applies the BGP palette and packs 4 shades per byte.
- Writes the bytes into a double-buffered framebuffer RAM that the video scan-out block reads.
- Tracks raster position from the PPU mode and swaps buffers at each V-blank.

---
 rtl/gb_fb_writer.sv | 166 ++++++++++++++++
 tb/tb_gb_fb_writer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_fb_writer.sv
// Framebuffer writer: palettes PPU pixel codes, packs four shades per byte and
// queues byte writes into a double-buffered framebuffer, swapping buffers at V-blank.
module gb_fb_writer #(
  parameter int FB_ADDR_W   = 14,
  parameter int LINE_PX     = 160,
  parameter int LINES       = 144,
  parameter int FRAME_BYTES = 5760,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           px_in,
  input  logic                 px_push,
  input  logic [1:0]           ppu_mode,
  input  logic [7:0]           bgp,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [7:0]           fb_wdata,
  input  logic                 fb_wr_ready,
  output logic                 disp_sel,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int XW             = $clog2(LINE_PX + 1);
  localparam int YW             = $clog2(LINES + 1);
  localparam int PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);
  localparam int BYTES_PER_LINE = LINE_PX / 4;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } ppu_mode_t;

  logic [1:0]           prev_mode;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [7:0]           pack;
  logic                 swap_pend;

  logic [FB_ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [7:0]           mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 mode3_entry;
  logic                 line_end;
  logic                 frame_end;
  logic [XW-1:0]        x_eff;
  logic [1:0]           shade;
  logic                 accept;
  logic [7:0]           pix_byte;
  logic                 enq_req;
  logic [FB_ADDR_W-1:0] enq_addr;
  logic [7:0]           enq_data;
  logic                 pop;
  logic                 full;
  logic                 enq_do;
  logic                 drop;
  logic                 swap_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A fresh draw period restarts the line, so a partial byte from an aborted line is dropped.
  always_comb begin
    mode3_entry = (ppu_mode == MODE_DRAW) && (prev_mode != MODE_DRAW);
    line_end    = (prev_mode == MODE_DRAW) && (ppu_mode == MODE_HBLANK);
    frame_end   = (ppu_mode == MODE_VBLANK) && (prev_mode != MODE_VBLANK);
    x_eff       = mode3_entry ? '0 : x;
    shade       = bgp[{px_in, 1'b0} +: 2];
    accept      = px_push && (ppu_mode == MODE_DRAW) && !swap_pend &&
                  (x_eff < XW'(LINE_PX)) && (y < YW'(LINES));

    pix_byte = (x_eff[1:0] == 2'd0) ? 8'h00 : pack;
    case (x_eff[1:0])
      2'd0:    pix_byte[7:6] = shade;
      2'd1:    pix_byte[5:4] = shade;
      2'd2:    pix_byte[3:2] = shade;
      default: pix_byte[1:0] = shade;
    endcase

    enq_req  = (accept && (x_eff[1:0] == 2'd3)) || (line_end && (x_eff[1:0] != 2'd0));
    enq_data = accept ? pix_byte : pack;
    enq_addr = (disp_sel ? '0 : FB_ADDR_W'(FRAME_BYTES)) +
               FB_ADDR_W'(y) * FB_ADDR_W'(BYTES_PER_LINE) +
               FB_ADDR_W'(x_eff[XW-1:2]);

    fb_we     = (count != '0);
    fb_addr   = mem_addr[rd_ptr];
    fb_wdata  = mem_data[rd_ptr];
    pop       = fb_we && fb_wr_ready;
    full      = (count == CNT_W'(FIFO_DEPTH));
    enq_do    = enq_req && (!full || pop);
    drop      = enq_req && full && !pop;
    swap_fire = swap_pend && (count == '0) && !enq_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_mode  <= 2'd0;
      x          <= '0;
      y          <= '0;
      pack       <= 8'h00;
      swap_pend  <= 1'b0;
      disp_sel   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prev_mode  <= ppu_mode;
      frame_done <= swap_fire;
      if (drop) overflow <= 1'b1;

      if (swap_fire) begin
        swap_pend <= 1'b0;
        disp_sel  <= ~disp_sel;
      end else if (frame_end) begin
        swap_pend <= 1'b1;
      end

      if (swap_fire) begin
        x <= '0;
        y <= '0;
      end else if (line_end) begin
        x <= '0;
        if (y < YW'(LINES)) y <= y + 1'b1;
      end else if (accept) begin
        x    <= x_eff + 1'b1;
        pack <= pix_byte;
      end else if (mode3_entry) begin
        x <= '0;
      end
    end
  end

  // Write queue; the head entry drives the RAM port directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= 8'h00;
      end
    end else begin
      if (enq_do) begin
        mem_addr[wr_ptr] <= enq_addr;
        mem_data[wr_ptr] <= enq_data;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq_do, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_fb_writer.sv
// Directed bench for gb_fb_writer: a pixel-packing model pushes expected
// {addr, data} writes to a scoreboard queue that is checked as the RAM accepts them.
module tb_gb_fb_writer;

  localparam int FRAME_BYTES = 5760;

  logic        clk;
  logic        rst;
  logic [1:0]  px_in;
  logic        px_push;
  logic [1:0]  ppu_mode;
  logic [7:0]  bgp;
  logic        fb_we;
  logic [13:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_wr_ready;
  logic        disp_sel;
  logic        frame_done;
  logic        overflow;

  int          checks   = 0;
  int          failures = 0;
  logic [21:0] exp_q[$];
  logic        has_pend;
  logic [21:0] pend_val;
  int          m_x;
  int          m_y;
  logic        m_sel;
  logic        m_ovf;
  logic [7:0]  m_pack;

  gb_fb_writer dut (
    .clk         (clk),
    .rst         (rst),
    .px_in       (px_in),
    .px_push     (px_push),
    .ppu_mode    (ppu_mode),
    .bgp         (bgp),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .fb_wr_ready (fb_wr_ready),
    .disp_sel    (disp_sel),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [13:0] exp_addr(input int xi);
    return 14'((m_sel ? 0 : FRAME_BYTES) + m_y * 40 + xi / 4);
  endfunction

  // One clock: score any write the RAM takes this cycle, then queue or drop the pending byte.
  task automatic step();
    logic [21:0] e;
    @(negedge clk);
    if (rst && fb_we && fb_wr_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("[TB] FAIL spurious_write observed addr=%0d expected no write", fb_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("wr_addr", 32'(fb_addr), 32'(e[21:8]));
        check_output("wr_data", 32'(fb_wdata), 32'(e[7:0]));
      end
    end
    if (has_pend) begin
      if (exp_q.size() < 4) exp_q.push_back(pend_val);
      else m_ovf = 1'b1;
      has_pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] px);
    int pos;
    px_in   = px;
    px_push = 1'b1;
    if (ppu_mode == 2'd3 && m_x < 160 && m_y < 144) begin
      pos = m_x % 4;
      if (pos == 0) m_pack = 8'h00;
      m_pack[7 - 2 * pos -: 2] = bgp[2 * px +: 2];
      if (pos == 3) begin
        has_pend = 1'b1;
        pend_val = {exp_addr(m_x), m_pack};
      end
      m_x++;
    end
    step();
    px_push = 1'b0;
  endtask

  task automatic end_line(input logic [1:0] next_mode);
    ppu_mode = 2'd0;
    if (m_x % 4 != 0) begin
      has_pend = 1'b1;
      pend_val = {exp_addr(m_x), m_pack};
    end
    step();
    m_x = 0;
    if (m_y < 144) m_y++;
    ppu_mode = next_mode;
    step();
  endtask

  task automatic enter_draw();
    ppu_mode = 2'd3;
    m_x = 0;
    step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && (exp_q.size() != 0 || fb_we); i++) step();
    check_output(tag, 32'(exp_q.size()), 32'd0);
    check_output({tag, "_we"}, 32'(fb_we), 32'd0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    has_pend = 1'b0;
    m_x = 0;
    m_y = 0;
    m_sel = 1'b0;
    m_ovf = 1'b0;
    m_pack = 8'h00;
  endtask

  task automatic do_reset();
    px_push     = 1'b0;
    ppu_mode    = 2'd0;
    fb_wr_ready = 1'b1;
    rst         = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    int pulses;
    logic [21:0] head;
    rst = 1'b1;
    px_in = 2'd0;
    px_push = 1'b0;
    ppu_mode = 2'd0;
    bgp = 8'h00;
    fb_wr_ready = 1'b1;
    model_clear();
    #3 rst = 1'b0;
    #10;
    check_output("rst_fb_we", 32'(fb_we), 32'd0);
    check_output("rst_fb_addr", 32'(fb_addr), 32'd0);
    check_output("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    check_output("rst_disp_sel", 32'(disp_sel), 32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] first byte latency and palette");
    bgp = 8'hE4;
    enter_draw();
    apply_stimulus(2'd0);
    apply_stimulus(2'd1);
    apply_stimulus(2'd2);
    check_output("no_we_before_byte", 32'(fb_we), 32'd0);
    apply_stimulus(2'd3);
    check_output("first_we", 32'(fb_we), 32'd1);
    check_output("first_addr", 32'(fb_addr), 32'd5760);
    check_output("first_data", 32'(fb_wdata), 32'h1B);
    drain("t1_drain");

    $display("[TB] full line and line advance");
    do_reset();
    bgp = 8'h1B;
    enter_draw();
    for (int i = 0; i < 161; i++) apply_stimulus(2'd3);
    end_line(2'd3);
    bgp = 8'hE4;
    for (int i = 0; i < 4; i++) apply_stimulus(2'(i));
    check_output("line1_addr", 32'(fb_addr), 32'd5800);
    drain("t2_drain");
    check_output("t2_overflow", 32'(overflow), 32'd0);

    $display("[TB] partial byte and mid-line restart");
    do_reset();
    bgp = 8'hE4;
    enter_draw();
    apply_stimulus(2'd3);
    apply_stimulus(2'd2);
    apply_stimulus(2'd1);
    apply_stimulus(2'd0);
    apply_stimulus(2'd3);
    apply_stimulus(2'd2);
    end_line(2'd3);
    apply_stimulus(2'd1);
    apply_stimulus(2'd1);
    ppu_mode = 2'd2;
    step();
    enter_draw();
    for (int i = 0; i < 4; i++) apply_stimulus(2'(3 - i));
    drain("t3_drain");

    $display("[TB] backpressure and overflow");
    do_reset();
    bgp = 8'hD2;
    enter_draw();
    fb_wr_ready = 1'b0;
    for (int i = 0; i < 24; i++) apply_stimulus(2'((i * 3 + 1) % 4));
    for (int i = 0; i < 6; i++) begin
      step();
      head = exp_q[0];
      check_output("head_addr_stable", 32'(fb_addr), 32'(head[21:8]));
      check_output("head_data_stable", 32'(fb_wdata), 32'(head[7:0]));
    end
    check_output("overflow_set", 32'(overflow), 32'(m_ovf));
    fb_wr_ready = 1'b1;
    drain("t4_drain");
    check_output("overflow_sticky", 32'(overflow), 32'd1);

    $display("[TB] full frame and buffer swap");
    do_reset();
    bgp = 8'hE4;
    enter_draw();
    for (int ln = 0; ln < 144; ln++) begin
      for (int i = 0; i < 160; i++) begin
        if (ln == 143 && i >= 153) fb_wr_ready = 1'b0;
        apply_stimulus(2'((ln + i) % 4));
      end
      end_line(ln == 143 ? 2'd1 : 2'd3);
    end
    check_output("vblank_pending_we", 32'(fb_we), 32'd1);
    check_output("no_early_swap", 32'(frame_done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      fb_wr_ready = 1'(i % 2);
      step();
      if (frame_done) begin
        pulses++;
        check_output("swap_fifo_empty", 32'(fb_we), 32'd0);
        check_output("swap_after_last_pop", 32'(exp_q.size()), 32'd0);
      end
    end
    check_output("frame_done_pulses", 32'(pulses), 32'd1);
    check_output("disp_sel_swapped", 32'(disp_sel), 32'd1);
    m_sel = 1'b1;
    m_x = 0;
    m_y = 0;
    ppu_mode = 2'd2;
    step();
    fb_wr_ready = 1'b1;
    enter_draw();
    apply_stimulus(2'd1);
    apply_stimulus(2'd1);
    apply_stimulus(2'd2);
    apply_stimulus(2'd3);
    check_output("frame2_addr", 32'(fb_addr), 32'd0);

    $display("[TB] asynchronous reset mid-write");
    fb_wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(2'(i % 4));
    check_output("pre_reset_we", 32'(fb_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_we", 32'(fb_we), 32'd0);
    check_output("async_rst_disp_sel", 32'(disp_sel), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    fb_wr_ready = 1'b1;
    enter_draw();
    for (int i = 0; i < 4; i++) apply_stimulus(2'(i));
    check_output("post_reset_addr", 32'(fb_addr), 32'd5760);
    drain("t6_drain");
    check_output("final_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
